// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the operand access unit.
//   - Addressing-mode constants, matching the instruction di bit.
//   - State encoding of the operand access sequencer.
//   - Legal memory read latency range and the latency counter width.
// No ports (package).
package cpu_pkg;

    localparam logic ADDR_DIRECT   = 1'b0;
    localparam logic ADDR_INDIRECT = 1'b1;

    localparam int unsigned MemLatencyMin = 1;
    localparam int unsigned MemLatencyMax = 4;
    localparam int unsigned OauCntWidth   = 3;

    typedef enum logic [2:0] {
        OauIdle,
        OauPtrWait,
        OauRdWait,
        OauWr,
        OauResp
    } oau_state_e;

    // Keeps an out-of-range latency parameter inside what the counter can express.
    function automatic int unsigned clamp_mem_latency(input int unsigned lat);
        if (lat < MemLatencyMin) begin
            return MemLatencyMin;
        end
        if (lat > MemLatencyMax) begin
            return MemLatencyMax;
        end
        return lat;
    endfunction

endpackage

// File: rtl/operand_access_unit_if.sv
// Request/response and data-memory signal bundle of the operand access unit.
//   slave  : the operand access unit's view.
//   master : the environment's view (control FSM on the request side, data memory on the
//            memory side).
// Signals:
//   req_valid/req_ready/req_write/req_ind/req_addr/req_wdata : request channel
//   rsp_valid/rsp_data/rsp_err                               : response pulse and data
//   mem_addr/mem_we/mem_wdata/mem_rdata                      : single-port data memory
interface operand_access_unit_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_ind;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_err;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  req_valid, req_write, req_ind, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req_valid, req_write, req_ind, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/register.sv
// Generic holding register with synchronous load and clear.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears q_o
//   ld_i  : load d_i
//   cl_i  : clear to zero (wins over ld_i)
//   d_i   : data in
//   q_o   : registered value
module register #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic             cl_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] val_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q <= '0;
        end else if (cl_i) begin
            val_q <= '0;
        end else if (ld_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/operand_access_unit.sv
// Operand/result memory sequencer: one read or write request at a time, direct or one-level
// indirect, against a single-port memory with MEM_LATENCY cycles of read latency. Returns a
// one-cycle response pulse with read data or completion.
//   clk   : clock
//   rst_n : asynchronous active-low reset; aborts any in-flight request
//   bus   : operand_access_unit_if.slave (request, response and memory signals)
module operand_access_unit
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned STRICT      = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_access_unit_if.slave bus
);

    localparam int unsigned            Lat    = clamp_mem_latency(MEM_LATENCY);
    localparam logic [OauCntWidth-1:0] LatCnt = OauCntWidth'(Lat);

    oau_state_e             state_q;
    logic [OauCntWidth-1:0] cnt_q;
    logic                   req_write_q;
    logic [DATA_WIDTH-1:0]  req_wdata_q;
    logic                   mem_we_q;
    logic [DATA_WIDTH-1:0]  mem_wdata_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;

    logic                   accept;
    logic                   lat_done;
    logic                   ptr_done;
    logic                   rd_done;
    logic                   ptr_bad;
    logic                   addr_ld;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q;
    logic                   data_ld;
    logic                   data_cl;
    logic [DATA_WIDTH-1:0]  rsp_data_q;

    // RESP also accepts, so a new request can follow a response with no idle cycle.
    assign bus.req_ready = (state_q == OauIdle) || (state_q == OauResp);

    always_comb begin
        accept   = bus.req_valid && bus.req_ready;
        // The counter is cleared at each launch; data is valid once it reaches the latency.
        lat_done = (cnt_q == LatCnt);
        ptr_done = (state_q == OauPtrWait) && lat_done;
        rd_done  = (state_q == OauRdWait) && lat_done;
        // Any set bit above the address field means the pointer does not fit the memory.
        ptr_bad  = (STRICT != 0) && ((bus.mem_rdata >> ADDR_WIDTH) != '0);
        addr_ld  = accept || (ptr_done && !ptr_bad);
        addr_d   = accept ? bus.req_addr : bus.mem_rdata[ADDR_WIDTH-1:0];
        data_cl  = accept;
        data_ld  = rd_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= OauIdle;
            cnt_q       <= '0;
            req_write_q <= 1'b0;
            req_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            unique case (state_q)
                OauIdle, OauResp: begin
                    if (accept) begin
                        req_write_q <= bus.req_write;
                        req_wdata_q <= bus.req_wdata;
                        cnt_q       <= '0;
                        rsp_err_q   <= 1'b0;
                        if (bus.req_ind == ADDR_INDIRECT) begin
                            state_q <= OauPtrWait;
                        end else if (bus.req_write) begin
                            state_q     <= OauWr;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= bus.req_wdata;
                        end else begin
                            state_q <= OauRdWait;
                        end
                    end else begin
                        state_q <= OauIdle;
                    end
                end
                OauPtrWait: begin
                    if (lat_done) begin
                        cnt_q <= '0;
                        if (ptr_bad) begin
                            // No second access: respond straight away with the error.
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= OauResp;
                        end else if (req_write_q) begin
                            state_q     <= OauWr;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= req_wdata_q;
                        end else begin
                            state_q <= OauRdWait;
                        end
                    end else begin
                        cnt_q <= cnt_q + OauCntWidth'(1);
                    end
                end
                OauRdWait: begin
                    if (lat_done) begin
                        rsp_valid_q <= 1'b1;
                        state_q     <= OauResp;
                    end else begin
                        cnt_q <= cnt_q + OauCntWidth'(1);
                    end
                end
                OauWr: begin
                    rsp_valid_q <= 1'b1;
                    state_q     <= OauResp;
                end
                default: begin
                    state_q <= OauIdle;
                end
            endcase
        end
    end

    register #(
        .Width (ADDR_WIDTH)
    ) u_mem_addr_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (addr_ld),
        .cl_i  (1'b0),
        .d_i   (addr_d),
        .q_o   (mem_addr_q)
    );

    register #(
        .Width (DATA_WIDTH)
    ) u_rsp_data_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_i  (data_ld),
        .cl_i  (data_cl),
        .d_i   (bus.mem_rdata),
        .q_o   (rsp_data_q)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_operand_access_unit.sv
// Bench for operand_access_unit. Three instances: 0 = latency 1 truncating, 1 = latency 1
// strict, 2 = latency 3 truncating. Each has its own latency-accurate memory. A model keeps,
// per instance, the timing and values the outputs must show for the last accepted request.
module tb_operand_access_unit;

    localparam int NDut = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [NDut-1:0] req_valid = '0;
    logic [NDut-1:0] req_write = '0;
    logic [NDut-1:0] req_ind   = '0;
    logic [5:0]      req_addr  [NDut];
    logic [15:0]     req_wdata [NDut];
    logic [NDut-1:0] rdy;
    logic [NDut-1:0] rv;
    logic [NDut-1:0] rerr;
    logic [NDut-1:0] we;
    logic [15:0]     rdata   [NDut];
    logic [15:0]     wdata_o [NDut];
    logic [5:0]      maddr   [NDut];

    logic [15:0] mem    [NDut][64] = '{default: '0};
    logic [15:0] pipe   [NDut][4];
    logic [15:0] shadow [NDut][64] = '{default: '0};

    logic        poke_en = 1'b0;
    int          poke_d  = 0;
    logic [5:0]  poke_a  = '0;
    logic [15:0] poke_v  = '0;

    for (genvar g = 0; g < NDut; g++) begin : g_dut
        localparam int unsigned GL = (g == 2) ? 3 : 1;
        localparam int unsigned GS = (g == 1) ? 1 : 0;
        operand_access_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(6)) bus ();
        assign bus.req_valid = req_valid[g];
        assign bus.req_write = req_write[g];
        assign bus.req_ind   = req_ind[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.req_wdata = req_wdata[g];
        assign bus.mem_rdata = pipe[g][GL-1];
        assign rdy[g]        = bus.req_ready;
        assign rv[g]         = bus.rsp_valid;
        assign rerr[g]       = bus.rsp_err;
        assign we[g]         = bus.mem_we;
        assign rdata[g]      = bus.rsp_data;
        assign wdata_o[g]    = bus.mem_wdata;
        assign maddr[g]      = bus.mem_addr;
        operand_access_unit #(
            .DATA_WIDTH  (16),
            .ADDR_WIDTH  (6),
            .MEM_LATENCY (GL),
            .STRICT      (GS)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Synchronous memories: address sampled at an edge, data out after GL edges.
    always @(posedge clk) begin
        for (int d = 0; d < NDut; d++) begin
            for (int s = 3; s > 0; s--) pipe[d][s] <= pipe[d][s-1];
            pipe[d][0] <= mem[d][maddr[d]];
            if (we[d]) mem[d][maddr[d]] = wdata_o[d];
        end
        if (poke_en) mem[poke_d][poke_a] = poke_v;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance (cycle numbers are edge counts).
    int          n_acc [NDut];
    int          rsp_at [NDut];
    int          we_at [NDut];
    int          sw_at [NDut];
    logic [5:0]  addr_first [NDut];
    logic [5:0]  addr_fin [NDut];
    logic [15:0] exp_data [NDut];
    logic        exp_err [NDut];
    logic [15:0] wd_old [NDut];
    logic [15:0] wd_new [NDut];
    int          rsp_seen [NDut];
    int          we_cnt [NDut];

    function automatic int lat_of(input int d);
        return (d == 2) ? 3 : 1;
    endfunction

    function automatic bit strict_of(input int d);
        return d == 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < NDut; d++) begin
            n_acc[d]      = -100;
            rsp_at[d]     = -100;
            we_at[d]      = -100;
            sw_at[d]      = 0;
            addr_first[d] = '0;
            addr_fin[d]   = '0;
            exp_data[d]   = '0;
            exp_err[d]    = 1'b0;
            wd_old[d]     = '0;
            wd_new[d]     = '0;
        end
    endtask

    task automatic compare_all();
        bit busy;
        for (int d = 0; d < NDut; d++) begin
            busy = (cyc >= n_acc[d]) && (cyc < rsp_at[d]);
            chk($sformatf("dut%0d req_ready", d), rdy[d], !busy);
            chk($sformatf("dut%0d rsp_valid", d), rv[d], cyc == rsp_at[d]);
            chk($sformatf("dut%0d mem_we", d), we[d], cyc == we_at[d]);
            chk($sformatf("dut%0d rsp_data", d), rdata[d], busy ? 16'h0 : exp_data[d]);
            chk($sformatf("dut%0d rsp_err", d), rerr[d], busy ? 1'b0 : exp_err[d]);
            chk($sformatf("dut%0d mem_addr", d), maddr[d],
                (cyc >= sw_at[d]) ? addr_fin[d] : addr_first[d]);
            chk($sformatf("dut%0d mem_wdata", d), wdata_o[d],
                (cyc >= we_at[d]) ? wd_new[d] : wd_old[d]);
            if (rv[d]) rsp_seen[d] = cyc;
            if (we[d]) we_cnt[d]++;
        end
    endtask

    task automatic poke(input int d, input logic [5:0] a, input logic [15:0] v);
        poke_en = 1'b1;
        poke_d  = d;
        poke_a  = a;
        poke_v  = v;
        @(posedge clk);
        #1;
        poke_en      = 1'b0;
        shadow[d][a] = v;
    endtask

    // Issue one request, update the model at the accept edge, return just after the
    // negedge of the response cycle (so a follow-up call lands in the RESP cycle).
    task automatic do_req(input int d, input bit wr, input bit ind, input logic [5:0] a,
                          input logic [15:0] wd, input bit abort);
        logic [15:0] ptr;
        logic [5:0]  eff;
        bit          err;
        int          n;
        int          l;
        int          guard;
        l            = lat_of(d);
        req_write[d] = wr;
        req_ind[d]   = ind;
        req_addr[d]  = a;
        req_wdata[d] = wd;
        req_valid[d] = 1'b1;
        chk($sformatf("dut%0d ready at request", d), rdy[d], 1'b1);
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        n   = cyc;
        ptr = shadow[d][a];
        err = ind && strict_of(d) && (ptr > 16'd63);
        eff = ind ? ptr[5:0] : a;
        n_acc[d] = n;
        if (!wr && !ind)     rsp_at[d] = n + 1 + l;
        else if (!wr && ind) rsp_at[d] = err ? n + 1 + l : n + 2 + 2 * l;
        else if (!ind)       rsp_at[d] = n + 1;
        else                 rsp_at[d] = err ? n + 1 + l : n + 2 + l;
        if (wr && !err) begin
            we_at[d]  = ind ? n + 1 + l : n;
            wd_old[d] = wd_new[d];
            wd_new[d] = wd;
        end else begin
            we_at[d] = -100;
        end
        exp_data[d]   = (wr || err) ? 16'h0 : shadow[d][eff];
        exp_err[d]    = err;
        addr_first[d] = a;
        addr_fin[d]   = (ind && !err) ? eff : a;
        sw_at[d]      = (ind && !err) ? n + 1 + l : n;
        if (abort) begin
            rst_n = 1'b0;
            reset_model();
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            return;
        end
        guard = 0;
        while (cyc < rsp_at[d] && guard < 64) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 64) chk($sformatf("dut%0d response wait expired", d), cyc, rsp_at[d]);
        @(negedge clk);
        #1;
        if (wr && !err) shadow[d][eff] = wd;
    endtask

    initial begin
        int w0;
        int first_rsp;
        int bad;
        for (int d = 0; d < NDut; d++) begin
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_seen[d]  = -1;
            we_cnt[d]    = 0;
        end
        reset_model();
        fork
            begin
                forever begin
                    @(negedge clk);
                    compare_all();
                end
            end
            begin
                @(negedge clk);
                #1;
                chk("reset req_ready", rdy[0], 1'b1);
                chk("reset rsp_valid", rv[0], 1'b0);
                chk("reset rsp_data", rdata[0], 16'h0);
                chk("reset rsp_err", rerr[0], 1'b0);
                chk("reset mem_addr", maddr[0], 6'd0);
                chk("reset mem_we", we[0], 1'b0);
                chk("reset mem_wdata", wdata_o[0], 16'h0);

                poke(0, 6'd5, 16'h1234);
                poke(0, 6'd3, 16'h0009);
                poke(0, 6'd9, 16'hBEEF);
                poke(0, 6'd10, 16'h0020);
                poke(0, 6'd4, 16'h0100);
                poke(0, 6'd0, 16'h5A5A);
                poke(0, 6'd11, 16'h0030);
                poke(1, 6'd4, 16'h0100);
                poke(1, 6'd0, 16'h5A5A);
                poke(2, 6'd5, 16'h1234);
                poke(2, 6'd6, 16'h7777);
                rst_n = 1'b1;
                repeat (2) @(posedge clk);
                #1;

                // Direct read.
                w0 = we_cnt[0];
                do_req(0, 1'b0, 1'b0, 6'd5, 16'h0, 1'b0);
                chk("direct read data", rdata[0], 16'h1234);
                chk("direct read latency", rsp_seen[0] - n_acc[0], 2);
                chk("direct read no write", we_cnt[0] - w0, 0);

                // Indirect read through mem[3] = 9.
                do_req(0, 1'b0, 1'b1, 6'd3, 16'h0, 1'b0);
                chk("indirect read data", rdata[0], 16'hBEEF);
                chk("indirect read latency", rsp_seen[0] - n_acc[0], 4);
                chk("indirect read final addr", maddr[0], 6'd9);

                // Indirect write through mem[10] = 0x20.
                w0 = we_cnt[0];
                do_req(0, 1'b1, 1'b1, 6'd10, 16'hA5A5, 1'b0);
                chk("indirect write latency", rsp_seen[0] - n_acc[0], 3);
                chk("indirect write we cycles", we_cnt[0] - w0, 1);
                chk("indirect write rsp_data", rdata[0], 16'h0);
                chk("indirect write memory", mem[0][32], 16'hA5A5);

                // Out-of-range pointer, strict.
                w0 = we_cnt[1];
                do_req(1, 1'b0, 1'b1, 6'd4, 16'h0, 1'b0);
                chk("strict err flag", rerr[1], 1'b1);
                chk("strict err data", rdata[1], 16'h0);
                chk("strict err latency", rsp_seen[1] - n_acc[1], 2);
                chk("strict err addr held", maddr[1], 6'd4);
                chk("strict err no write", we_cnt[1] - w0, 0);

                // Same pointer, truncating: reads mem[0].
                do_req(0, 1'b0, 1'b1, 6'd4, 16'h0, 1'b0);
                chk("truncated read data", rdata[0], 16'h5A5A);
                chk("truncated read err", rerr[0], 1'b0);
                chk("truncated read addr", maddr[0], 6'd0);

                // Latency 3 direct read, then back-to-back request in the RESP cycle.
                do_req(2, 1'b0, 1'b0, 6'd5, 16'h0, 1'b0);
                chk("L3 read latency", rsp_seen[2] - n_acc[2], 4);
                chk("L3 read data", rdata[2], 16'h1234);
                first_rsp = rsp_seen[2];
                do_req(2, 1'b0, 1'b0, 6'd6, 16'h0, 1'b0);
                chk("back-to-back accept edge", n_acc[2], first_rsp + 1);
                chk("back-to-back data", rdata[2], 16'h7777);

                // Direct write.
                do_req(2, 1'b1, 1'b0, 6'd8, 16'h3C3C, 1'b0);
                chk("direct write latency", rsp_seen[2] - n_acc[2], 1);
                chk("direct write memory", mem[2][8], 16'h3C3C);

                // Reset during PTR_WAIT of an indirect write through mem[11] = 0x30.
                w0 = we_cnt[0];
                do_req(0, 1'b1, 1'b1, 6'd11, 16'hDEAD, 1'b1);
                repeat (4) @(posedge clk);
                #1;
                chk("abort no write", we_cnt[0] - w0, 0);
                chk("abort ready", rdy[0], 1'b1);
                chk("abort memory untouched", mem[0][48], 16'h0);

                do_req(0, 1'b0, 1'b0, 6'd5, 16'h0, 1'b0);
                chk("read after abort", rdata[0], 16'h1234);

                repeat (3) @(posedge clk);
                #1;
                bad = 0;
                for (int d = 0; d < NDut; d++) begin
                    for (int a = 0; a < 64; a++) begin
                        if (mem[d][a] !== shadow[d][a]) bad++;
                    end
                end
                chk("memory contents", bad, 0);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
